// File: rtl/traffic_pkg.sv
// Shared lamp-word encoding, fault codes and the legality helper for the
// traffic conflict monitor.
package traffic_pkg;

    // {left, green, yellow, red}
    localparam logic [3:0] LEFT   = 4'b1001;
    localparam logic [3:0] GREEN  = 4'b0100;
    localparam logic [3:0] YELLOW = 4'b0010;
    localparam logic [3:0] RED    = 4'b0001;

    typedef enum logic [2:0] {
        FC_NONE         = 3'd0,
        FC_CONFLICT     = 3'd1,
        FC_ILLEGAL_NS   = 3'd2,
        FC_ILLEGAL_EW   = 3'd3,
        FC_SEQ_NS       = 3'd4,
        FC_SEQ_EW       = 3'd5,
        FC_SHORT_YELLOW = 3'd6,
        FC_STUCK        = 3'd7
    } fault_code_t;

    function automatic logic is_legal(input logic [3:0] word);
        return (word == LEFT) || (word == GREEN) || (word == YELLOW) || (word == RED);
    endfunction

endpackage

// File: rtl/lamp_channel_checker.sv
// Per-direction lamp checker: word legality, phase sequencing, yellow dwell
// and stuck-word detection. Outputs are single-cycle pulses.
module lamp_channel_checker
    import traffic_pkg::*;
#(
    parameter int MIN_YELLOW = 3,
    parameter int MAX_DWELL  = 31,
    parameter int DWELL_W    = 5
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rearm_i,
    input  logic [3:0] lamps_i,
    input  logic       emergency_i,
    output logic       illegal_o,
    output logic       seq_err_o,
    output logic       short_yellow_o,
    output logic       stuck_o
);

    localparam logic [DWELL_W-1:0] DW_MAX = DWELL_W'(MAX_DWELL);
    localparam logic [DWELL_W-1:0] DW_MIN_Y = DWELL_W'(MIN_YELLOW);
    localparam logic [DWELL_W-1:0] DW_ONE = DWELL_W'(1);

    logic [3:0]         prev_q, prev_d;
    logic [DWELL_W-1:0] dwell_q, dwell_d;
    logic               emg_seen_q, emg_seen_d;
    logic               armed_q, armed_d;

    logic changed, emg, trans_ok, leaving_red;

    always_comb begin
        changed     = (lamps_i != prev_q);
        emg         = emg_seen_q | emergency_i;
        leaving_red = changed && (prev_q == RED);

        trans_ok = (lamps_i == RED);
        case (prev_q)
            LEFT:    trans_ok = trans_ok | (lamps_i == GREEN);
            GREEN:   trans_ok = trans_ok | (lamps_i == YELLOW);
            // Resuming the pre-emergency phase straight out of all-stop is allowed.
            RED:     trans_ok = trans_ok | (lamps_i == LEFT) |
                                (emg && ((lamps_i == GREEN) || (lamps_i == YELLOW)));
            default: ;
        endcase

        illegal_o      = !is_legal(lamps_i);
        seq_err_o      = 1'b0;
        short_yellow_o = 1'b0;
        stuck_o        = 1'b0;
        prev_d         = lamps_i;
        armed_d        = 1'b1;

        if (!armed_q) begin
            dwell_d    = DW_ONE;
            emg_seen_d = emergency_i;
        end else begin
            if (changed)
                dwell_d = DW_ONE;
            else if (emergency_i || dwell_q == DW_MAX)
                dwell_d = dwell_q;
            else
                dwell_d = dwell_q + DW_ONE;
            emg_seen_d     = emergency_i | (emg_seen_q & !leaving_red);
            seq_err_o      = changed && !trans_ok;
            short_yellow_o = changed && (prev_q == YELLOW) && (lamps_i == RED) &&
                             (dwell_q < DW_MIN_Y) && !emg;
            stuck_o        = !emergency_i && (dwell_d == DW_MAX);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n || rearm_i) begin
            prev_q     <= RED;
            dwell_q    <= '0;
            emg_seen_q <= 1'b0;
            armed_q    <= 1'b0;
        end else begin
            prev_q     <= prev_d;
            dwell_q    <= dwell_d;
            emg_seen_q <= emg_seen_d;
            armed_q    <= armed_d;
        end
    end

endmodule

// File: rtl/traffic_conflict_monitor.sv
// Safety monitor on the NS/EW lamp buses: detects conflicts and per-channel
// violations, latches the first fault code and requests flash-red.
module traffic_conflict_monitor
    import traffic_pkg::*;
#(
    parameter int MIN_YELLOW = 3,
    parameter int MAX_DWELL  = 31,
    parameter int DWELL_W    = 5
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] ns_lamps,
    input  logic [3:0] ew_lamps,
    input  logic       emergency,
    input  logic       fault_clear,
    output logic       fault,
    output logic [2:0] fault_code,
    output logic       flash_red
);

    logic        fault_q, fault_d;
    fault_code_t code_q, code_d, code_now;

    logic ns_ill, ns_seq, ns_sy, ns_stuck;
    logic ew_ill, ew_seq, ew_sy, ew_stuck;
    logic conflict, clear_ok;

    // Clearing is only safe once both directions already show red.
    assign clear_ok = fault_clear && fault_q && (ns_lamps == RED) && (ew_lamps == RED);
    assign conflict = (ns_lamps != RED) && (ew_lamps != RED);

    lamp_channel_checker #(
        .MIN_YELLOW(MIN_YELLOW), .MAX_DWELL(MAX_DWELL), .DWELL_W(DWELL_W)
    ) u_ns (
        .clk(clk), .rst_n(rst_n), .rearm_i(clear_ok), .lamps_i(ns_lamps),
        .emergency_i(emergency), .illegal_o(ns_ill), .seq_err_o(ns_seq),
        .short_yellow_o(ns_sy), .stuck_o(ns_stuck)
    );

    lamp_channel_checker #(
        .MIN_YELLOW(MIN_YELLOW), .MAX_DWELL(MAX_DWELL), .DWELL_W(DWELL_W)
    ) u_ew (
        .clk(clk), .rst_n(rst_n), .rearm_i(clear_ok), .lamps_i(ew_lamps),
        .emergency_i(emergency), .illegal_o(ew_ill), .seq_err_o(ew_seq),
        .short_yellow_o(ew_sy), .stuck_o(ew_stuck)
    );

    always_comb begin
        code_now = FC_NONE;
        if (conflict)                  code_now = FC_CONFLICT;
        else if (ns_ill)               code_now = FC_ILLEGAL_NS;
        else if (ew_ill)               code_now = FC_ILLEGAL_EW;
        else if (ns_seq)               code_now = FC_SEQ_NS;
        else if (ew_seq)               code_now = FC_SEQ_EW;
        else if (ns_sy || ew_sy)       code_now = FC_SHORT_YELLOW;
        else if (ns_stuck || ew_stuck) code_now = FC_STUCK;

        fault_d = fault_q;
        code_d  = code_q;
        if (clear_ok) begin
            fault_d = 1'b0;
            code_d  = FC_NONE;
        end else if (!fault_q && code_now != FC_NONE) begin
            fault_d = 1'b1;
            code_d  = code_now;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            fault_q <= 1'b0;
            code_q  <= FC_NONE;
        end else begin
            fault_q <= fault_d;
            code_q  <= code_d;
        end
    end

    assign fault      = fault_q;
    assign flash_red  = fault_q;
    assign fault_code = code_q;

endmodule

// File: tb/tb_traffic_conflict_monitor.sv
// Directed, table-driven bench for traffic_conflict_monitor.
module tb_traffic_conflict_monitor;

    localparam logic [3:0] L = 4'b1001;
    localparam logic [3:0] G = 4'b0100;
    localparam logic [3:0] Y = 4'b0010;
    localparam logic [3:0] R = 4'b0001;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] ns_lamps, ew_lamps;
    logic       emergency, fault_clear;
    logic       fault, flash_red;
    logic [2:0] fault_code;

    int checks = 0;
    int errors = 0;

    typedef struct {
        string      name;
        logic       rst_n;
        logic [3:0] ns;
        logic [3:0] ew;
        logic       emg;
        logic       clr;
        logic       ef;
        logic [2:0] ec;
    } vec_t;

    vec_t tbl[$];

    traffic_conflict_monitor dut (
        .clk(clk), .rst_n(rst_n), .ns_lamps(ns_lamps), .ew_lamps(ew_lamps),
        .emergency(emergency), .fault_clear(fault_clear),
        .fault(fault), .fault_code(fault_code), .flash_red(flash_red)
    );

    always #5 clk = ~clk;

    task automatic add(input string name, input logic r, input logic [3:0] ns,
                       input logic [3:0] ew, input logic emg, input logic clr,
                       input logic ef, input logic [2:0] ec);
        vec_t v;
        v.name = name; v.rst_n = r; v.ns = ns; v.ew = ew;
        v.emg = emg; v.clr = clr; v.ef = ef; v.ec = ec;
        tbl.push_back(v);
    endtask

    task automatic add_rst();
        add("reset", 1'b0, R, R, 1'b0, 1'b0, 1'b0, 3'd0);
        add("reset", 1'b0, R, R, 1'b0, 1'b0, 1'b0, 3'd0);
    endtask

    // Apply one sample, then compare outputs just after the capturing edge.
    task automatic apply(input vec_t v, input int idx);
        rst_n = v.rst_n; ns_lamps = v.ns; ew_lamps = v.ew;
        emergency = v.emg; fault_clear = v.clr;
        @(posedge clk);
        #1;
        checks++;
        if (fault !== v.ef || flash_red !== v.ef || fault_code !== v.ec) begin
            errors++;
            $display("FAIL %s[%0d]: got fault=%b flash_red=%b code=%0d, want fault=%b flash_red=%b code=%0d",
                     v.name, idx, fault, flash_red, fault_code, v.ef, v.ef, v.ec);
        end
    endtask

    task automatic step(input string name, input logic r, input logic [3:0] ns,
                        input logic [3:0] ew, input logic clr,
                        input logic ef, input logic [2:0] ec);
        vec_t v;
        v.name = name; v.rst_n = r; v.ns = ns; v.ew = ew;
        v.emg = 1'b0; v.clr = clr; v.ef = ef; v.ec = ec;
        apply(v, 0);
    endtask

    initial begin
        logic [3:0] ns_w, ew_w;
        rst_n = 1'b0; ns_lamps = R; ew_lamps = R; emergency = 1'b0; fault_clear = 1'b0;

        // ---- build the vector table ----
        add_rst();

        // Three full interleaved cycles: each direction L5 G10 Y3 while the other is red.
        for (int k = 0; k < 3; k++)
            for (int t = 0; t < 36; t++) begin
                ns_w = (t < 5) ? L : (t < 15) ? G : (t < 18) ? Y : R;
                ew_w = (t < 18) ? R : (t < 23) ? L : (t < 33) ? G : Y;
                add("nominal", 1'b1, ns_w, ew_w, 1'b0, 1'b0, 1'b0, 3'd0);
            end
        add_rst();

        add("conflict", 1'b1, G, L, 1'b0, 1'b0, 1'b1, 3'd1);
        add("conflict_hold", 1'b1, R, R, 1'b0, 1'b0, 1'b1, 3'd1);
        add_rst();
        add("prio_conflict_over_illegal", 1'b1, G, 4'b0110, 1'b0, 1'b0, 1'b1, 3'd1);
        add_rst();
        add("illegal_ns", 1'b1, 4'b0011, R, 1'b0, 1'b0, 1'b1, 3'd2);
        add_rst();

        // Emergency resume: RED->GREEN allowed after an emergency pulse.
        add("emg_resume", 1'b1, R, R, 1'b0, 1'b0, 1'b0, 3'd0);
        for (int i = 0; i < 2; i++) add("emg_resume", 1'b1, L, R, 1'b0, 1'b0, 1'b0, 3'd0);
        add("emg_resume", 1'b1, G, R, 1'b0, 1'b0, 1'b0, 3'd0);
        add("emg_resume", 1'b1, G, R, 1'b1, 1'b0, 1'b0, 3'd0);
        for (int i = 0; i < 4; i++) add("emg_resume", 1'b1, R, R, 1'b0, 1'b0, 1'b0, 3'd0);
        for (int i = 0; i < 3; i++) add("emg_resume", 1'b1, G, R, 1'b0, 1'b0, 1'b0, 3'd0);
        add_rst();

        // Same RED->GREEN without emergency is a sequence fault.
        add("seq_ns", 1'b1, R, R, 1'b0, 1'b0, 1'b0, 3'd0);
        for (int i = 0; i < 2; i++) add("seq_ns", 1'b1, L, R, 1'b0, 1'b0, 1'b0, 3'd0);
        for (int i = 0; i < 2; i++) add("seq_ns", 1'b1, G, R, 1'b0, 1'b0, 1'b0, 3'd0);
        for (int i = 0; i < 4; i++) add("seq_ns", 1'b1, R, R, 1'b0, 1'b0, 1'b0, 3'd0);
        add("seq_ns", 1'b1, G, R, 1'b0, 1'b0, 1'b1, 3'd4);
        add_rst();

        add("seq_ew", 1'b1, R, R, 1'b0, 1'b0, 1'b0, 3'd0);
        add("seq_ew", 1'b1, R, G, 1'b0, 1'b0, 1'b1, 3'd5);
        add_rst();

        // Short yellow on EW, then the same with emergency during yellow.
        for (int pass = 0; pass < 2; pass++) begin
            add("short_yellow", 1'b1, R, R, 1'b0, 1'b0, 1'b0, 3'd0);
            for (int i = 0; i < 2; i++) add("short_yellow", 1'b1, R, L, 1'b0, 1'b0, 1'b0, 3'd0);
            for (int i = 0; i < 2; i++) add("short_yellow", 1'b1, R, G, 1'b0, 1'b0, 1'b0, 3'd0);
            for (int i = 0; i < 2; i++) add("short_yellow", 1'b1, R, Y, pass[0], 1'b0, 1'b0, 3'd0);
            if (pass == 0) begin
                add("short_yellow", 1'b1, R, R, 1'b0, 1'b0, 1'b1, 3'd6);
            end else begin
                add("short_yellow_emg", 1'b1, R, R, 1'b0, 1'b0, 1'b0, 3'd0);
                add("short_yellow_emg", 1'b1, R, L, 1'b0, 1'b0, 1'b0, 3'd0);
            end
            add_rst();
        end

        // Stuck: the 31st identical sample trips the dwell limit.
        for (int i = 0; i < 30; i++) add("stuck_pre", 1'b1, G, R, 1'b0, 1'b0, 1'b0, 3'd0);
        add("stuck", 1'b1, G, R, 1'b0, 1'b0, 1'b1, 3'd7);
        add_rst();

        // Emergency freezes the dwell counter.
        for (int i = 0; i < 29; i++) add("stuck_emg", 1'b1, G, R, 1'b0, 1'b0, 1'b0, 3'd0);
        for (int i = 0; i < 5; i++)  add("stuck_emg", 1'b1, G, R, 1'b1, 1'b0, 1'b0, 3'd0);
        add("stuck_emg", 1'b1, G, R, 1'b0, 1'b0, 1'b0, 3'd0);
        add("stuck_emg", 1'b1, G, R, 1'b0, 1'b0, 1'b1, 3'd7);
        add_rst();

        // ---- apply the table ----
        for (int i = 0; i < tbl.size(); i++)
            apply(tbl[i], i);

        // ---- clear rules ----
        step("clr_setup", 1'b1, G, L, 1'b0, 1'b1, 3'd1);
        step("clr_ignored_ns_green", 1'b1, G, R, 1'b1, 1'b1, 3'd1);
        step("clr_accepted", 1'b1, R, R, 1'b1, 1'b0, 3'd0);
        // Re-armed: the first sample after a clear only loads state.
        step("clr_rearm_load", 1'b1, G, R, 1'b0, 1'b0, 3'd0);
        step("clr_rearm_yellow", 1'b1, Y, R, 1'b0, 1'b0, 3'd0);
        step("clr_rearm_short_y", 1'b1, R, R, 1'b0, 1'b1, 3'd6);
        step("latch_first_wins", 1'b1, G, L, 1'b0, 1'b1, 3'd6);
        // Reset mid-fault overrides an otherwise valid clear.
        step("reset_mid_fault", 1'b0, R, R, 1'b1, 1'b0, 3'd0);
        step("after_reset_clean", 1'b1, R, R, 1'b0, 1'b0, 3'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
